// File: rtl/sram_controller.sv
// sram_controller
//   Multi-cycle bridge between the MEM stage and a 16-bit asynchronous SRAM.
//   A 32-bit load or store becomes two 16-bit half-accesses:
//     - LOW handles the lower half-word.
//     - HIGH handles the upper half-word.
//   Each half-access is held on the bus for PHASE_CYCLES cycles. DONE then
//   releases the pipeline freeze for one cycle.
//
//   Parameters
//     PHASE_CYCLES  cycles per half-access (1..15)
//     BASE_ADDR     byte address mapped to SRAM word 0
//
//   Ports
//     clk, rst                   clock, synchronous active-high reset
//     wr_en, rd_en               store / load request from EXE/MEM
//     address, writeData         byte address and store data (sampled live)
//     readData                   load result, held until the next load completes
//     ready                      low while an access is in flight (pipeline freeze)
//     SRAM_ADDR                  half-word address on the SRAM bus
//     SRAM_DQ_out                write data to the pad
//     SRAM_DQ_oe                 pad output enable
//     SRAM_DQ_in                 read data from the pad
//     SRAM_WE_N, SRAM_OE_N       active-low write strobe / output enable
//     SRAM_CE_N, SRAM_UB_N,
//     SRAM_LB_N                  tied active
module sram_controller #(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        op_write, op_write_next;
  logic        req;
  logic        last;
  logic [31:0] offset;
  logic [16:0] word;
  logic        unused_offset_bits;

  assign req  = wr_en | rd_en;
  assign last = (cnt == LAST_CNT);

  // Full 32-bit subtraction, so addresses below BASE_ADDR wrap into the
  // top of the 2^17-word space instead of being rejected.
  assign offset             = address - BASE_ADDR;
  assign word               = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  assign ready     = ~req | (state == DONE);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_write <= 1'b0;
      readData <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      op_write <= op_write_next;
      // Capture each read half on the edge that ends its last bus cycle,
      // giving the asynchronous SRAM the full phase to settle.
      if (!op_write && last) begin
        if (state == LOW)  readData[15:0]  <= SRAM_DQ_in;
        if (state == HIGH) readData[31:16] <= SRAM_DQ_in;
      end
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    op_write_next = op_write;
    SRAM_ADDR     = '0;
    SRAM_DQ_out   = '0;
    SRAM_DQ_oe    = 1'b0;
    SRAM_WE_N     = 1'b1;
    SRAM_OE_N     = 1'b1;

    case (state)
      IDLE: begin
        // A simultaneous load and store request is treated as a store.
        if (req) begin
          state_next    = LOW;
          cnt_next      = 4'd0;
          op_write_next = wr_en;
        end
      end
      LOW: begin
        cnt_next  = last ? 4'd0 : cnt + 4'd1;
        SRAM_ADDR = {word, 1'b0};
        if (last) state_next = HIGH;
        if (op_write) begin
          SRAM_DQ_out = writeData[15:0];
          SRAM_DQ_oe  = 1'b1;
          SRAM_WE_N   = 1'b0;
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      HIGH: begin
        cnt_next  = last ? 4'd0 : cnt + 4'd1;
        SRAM_ADDR = {word, 1'b1};
        if (last) state_next = DONE;
        if (op_write) begin
          SRAM_DQ_out = writeData[31:16];
          SRAM_DQ_oe  = 1'b1;
          SRAM_WE_N   = 1'b0;
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
//   Directed and randomized bench for sram_controller. It uses two instances:
//     - dut:  default parameters, backed by a 16-bit SRAM array model.
//     - dut1: PHASE_CYCLES = 1, backed by a fixed address-derived read pattern.
//   The reference model is a map of 32-bit words keyed by the wrapped word index.
module tb_sram_controller;

  localparam int          P    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, writeData = '0;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
  logic        SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  logic        wr_en1 = 1'b0, rd_en1 = 1'b0;
  logic [31:0] address1 = '0, writeData1 = '0;
  logic [31:0] readData1;
  logic        ready1;
  logic [17:0] SRAM_ADDR1;
  logic [15:0] SRAM_DQ_out1, SRAM_DQ_in1;
  logic        SRAM_DQ_oe1, SRAM_WE_N1, SRAM_OE_N1, SRAM_CE_N1, SRAM_UB_N1, SRAM_LB_N1;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram [0:262143];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = '0;

  sram_controller #(.PHASE_CYCLES(P), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .writeData(writeData), .readData(readData), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
    .SRAM_DQ_in(SRAM_DQ_in), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  sram_controller #(.PHASE_CYCLES(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1),
    .address(address1), .writeData(writeData1), .readData(readData1), .ready(ready1),
    .SRAM_ADDR(SRAM_ADDR1), .SRAM_DQ_out(SRAM_DQ_out1), .SRAM_DQ_oe(SRAM_DQ_oe1),
    .SRAM_DQ_in(SRAM_DQ_in1), .SRAM_WE_N(SRAM_WE_N1), .SRAM_OE_N(SRAM_OE_N1),
    .SRAM_CE_N(SRAM_CE_N1), .SRAM_UB_N(SRAM_UB_N1), .SRAM_LB_N(SRAM_LB_N1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (SRAM_WE_N === 1'b0) sram[SRAM_ADDR] <= SRAM_DQ_out;
  end
  assign SRAM_DQ_in = (SRAM_OE_N === 1'b0) ? sram[SRAM_ADDR] : 16'h0000;

  function automatic logic [15:0] pat(input logic [17:0] h);
    return h[15:0] ^ 16'h5A5A;
  endfunction
  assign SRAM_DQ_in1 = (SRAM_OE_N1 === 1'b0) ? pat(SRAM_ADDR1) : 16'h0000;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not reach its end, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'h0001_FFFF);
  endfunction

  // One complete access on dut. The request first appears in an IDLE
  // cycle and is dropped in the cycle after DONE.
  task automatic do_access(input bit w, input bit r, input logic [31:0] a,
                           input logic [31:0] d);
    int          k;
    int          wd;
    bit          h;
    logic [31:0] exp_rd;
    wd = word_of(a);
    wr_en = w; rd_en = r; address = a; writeData = d;
    #1;
    check("req_idle_ready", ready, 1'b0);
    check("req_idle_we", SRAM_WE_N, 1'b1);
    k = 0;
    tick();
    while (ready !== 1'b1 && k < 40) begin
      h = (k >= P);
      check("phase_addr", SRAM_ADDR, {wd[16:0], h});
      if (w) begin
        check("wr_we_n", SRAM_WE_N, 1'b0);
        check("wr_oe_n", SRAM_OE_N, 1'b1);
        check("wr_dq_oe", SRAM_DQ_oe, 1'b1);
        check("wr_dq", SRAM_DQ_out, h ? d[31:16] : d[15:0]);
      end else begin
        check("rd_oe_n", SRAM_OE_N, 1'b0);
        check("rd_we_n", SRAM_WE_N, 1'b1);
        check("rd_dq_oe", SRAM_DQ_oe, 1'b0);
      end
      k++;
      tick();
    end
    check("latency", k, 2 * P);
    check("done_strobes", {SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe}, 3'b110);
    if (w) begin
      ref_mem[wd] = d;
      check("wr_hold_rd", readData, last_rd);
    end else begin
      exp_rd = ref_mem.exists(wd) ? ref_mem[wd] : 32'h0;
      check("rd_data", readData, exp_rd);
      last_rd = exp_rd;
    end
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    #1;
    check("after_ready", ready, 1'b1);
    check("after_rd_hold", readData, last_rd);
  endtask

  function automatic logic [31:0] pick_addr(input int s);
    logic [31:0] a;
    if (s < 8) a = BASE + 32'(4 * s);
    else       a = BASE - 32'(4 * (s - 7));
    return a;
  endfunction

  initial begin
    int          k;
    logic [31:0] a, d;
    int          op;

    // Reset
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_we_n", SRAM_WE_N, 1'b1);
    check("rst_oe_n", SRAM_OE_N, 1'b1);
    check("rst_dq_oe", SRAM_DQ_oe, 1'b0);
    check("rst_addr", SRAM_ADDR, 18'h0);
    check("rst_dq_out", SRAM_DQ_out, 16'h0);
    check("rst_rd", readData, 32'h0);
    check("rst_ready", ready, 1'b1);
    check("tie_pins", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 3'b000);

    // Idle pipeline: no freeze, no strobes
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ready", ready, 1'b1);
      check("idle_strobes", {SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe}, 3'b110);
    end

    // Directed store then load of 0xDEADBEEF at 1032 (SRAM half-words 4, 5)
    do_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
    check("sram_lo", {16'h0, sram[4]}, 32'h0000BEEF);
    check("sram_hi", {16'h0, sram[5]}, 32'h0000DEAD);
    do_access(1'b0, 1'b1, 32'd1032, 32'h0);
    check("load_deadbeef", readData, 32'hDEADBEEF);

    // Store and load together behave as a store
    do_access(1'b1, 1'b1, 32'd1036, 32'h1234_5678);
    do_access(1'b0, 1'b1, 32'd1036, 32'h0);

    // Fill the random address pool, including wrapped words below BASE
    for (int s = 0; s < 10; s++) do_access(1'b1, 1'b0, pick_addr(s), $urandom);

    // Randomized traffic with aliased and byte-offset addresses
    for (int i = 0; i < 40; i++) begin
      a = pick_addr($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) a = a + 32'h0008_0000;
      a = a + 32'($urandom_range(0, 3));
      d = $urandom;
      op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, a, d);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        check("gap_ready", ready, 1'b1);
        check("gap_strobes", {SRAM_WE_N, SRAM_OE_N}, 2'b11);
      end
    end

    // Reset during the HIGH phase of a store
    do_access(1'b0, 1'b1, 32'd1032, 32'h0);
    d = 32'hCAFE_F00D;
    wr_en = 1'b1; address = 32'd1060; writeData = d;
    for (int i = 0; i <= P; i++) tick();
    check("pre_rst_high_we", SRAM_WE_N, 1'b0);
    check("pre_rst_high_addr", SRAM_ADDR, {17'(word_of(32'd1060)), 1'b1});
    rst = 1'b1; wr_en = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    ref_mem[word_of(32'd1060)] = d;
    last_rd = 32'h0;
    check("midrst_we_n", SRAM_WE_N, 1'b1);
    check("midrst_dq_oe", SRAM_DQ_oe, 1'b0);
    check("midrst_rd", readData, 32'h0);
    check("midrst_ready", ready, 1'b1);
    check("midrst_addr", SRAM_ADDR, 18'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst_no_strobe", SRAM_WE_N, 1'b1);
    end
    do_access(1'b0, 1'b1, 32'd1060, 32'h0);

    // PHASE_CYCLES = 1: two back-to-back loads with one IDLE cycle between
    rd_en1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 32'd1040 : 32'd1236;
      address1 = a;
      #1;
      check("p1_idle_ready", ready1, 1'b0);
      check("p1_idle_oe_n", SRAM_OE_N1, 1'b1);
      k = 0;
      tick();
      while (ready1 !== 1'b1 && k < 20) begin
        check("p1_oe_n", SRAM_OE_N1, 1'b0);
        k++;
        tick();
      end
      check("p1_latency", k, 2);
      check("p1_rd", readData1,
            {pat({17'(word_of(a)), 1'b1}), pat({17'(word_of(a)), 1'b0})});
      tick();
    end
    rd_en1 = 1'b0;
    #1;
    check("p1_end_ready", ready1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
